muldiv_unit: RTL and testbench

Iterative multi-cycle multiply/divide engine producing the 2×WIDTH `mul_result` and `div_result` words consumed by the ALU's mul/div ALUOps. It sits beside the ALU in the execute stage and holds the pipeline through a valid/ready handshake. One operation is in flight at a time. Width is parametrised, and a flush input cancels work on pipeline redirect.

---
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide engine with valid/ready handshake.
// Optional MULDIV_SPECIAL_BYPASS_EN: divide-by-zero and signed-overflow DIV skip CALC.
//
// state  | meaning
// IDLE   | waiting for a request, in_ready high
// CALC   | one multiply or divide bit per cycle, counter runs down to zero
// FIX    | sign correction and special-case override
// DONE   | result held, out_valid high until out_ready
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   a_raw;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               dz;
    logic               ovf;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               req_dz;
    logic               req_ovf;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [2*WIDTH-1:0] fix_val;

    assign in_ready    = (state == S_IDLE);
    assign out_valid   = (state == S_DONE);
    assign result      = acc;
    assign div_by_zero = dz;

    // op[0] clear selects the signed variants
    assign a_neg   = !op[0] && a[WIDTH-1];
    assign b_neg   = !op[0] && b[WIDTH-1];
    assign a_mag   = a_neg ? -a : a;
    assign b_mag   = b_neg ? -b : b;
    assign req_dz  = op[1] && (b == '0);
    assign req_ovf = (op == 2'b10) && (a == MIN_NEG) && (b == ALL_ONES);

    // Multiply: acc = {partial hi, remaining multiplier bits}, shifted right each step
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opb};
    assign div_next  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign quo_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_comb begin
        fix_val = neg_res ? -acc : acc;
        if (is_div) begin
            if (dz)
                fix_val = {a_raw, ALL_ONES};
            else if (ovf)
                fix_val = {{WIDTH{1'b0}}, MIN_NEG};
            else
                fix_val = {rem_fix, quo_fix};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            opb     <= '0;
            a_raw   <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
            ovf     <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        cnt     <= CNT_LOAD;
                        acc     <= {{WIDTH{1'b0}}, a_mag};
                        opb     <= b_mag;
                        a_raw   <= a;
                        is_div  <= op[1];
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        dz      <= req_dz;
                        ovf     <= req_ovf;
`ifdef MULDIV_SPECIAL_BYPASS_EN
                        state   <= (req_dz || req_ovf) ? S_FIX : S_CALC;
`else
                        state   <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE)
                        state <= S_FIX;
                end
                S_FIX: begin
                    acc   <= fix_val;
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops against an arithmetic model.
module tb_muldiv_unit;

    localparam int          WIDTH = 32;
    localparam logic [31:0] MIN   = 32'h8000_0000;
    localparam logic [31:0] ONES  = 32'hFFFF_FFFF;
`ifdef MULDIV_SPECIAL_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        div_by_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Returns {div_by_zero, result} from plain integer arithmetic.
    function automatic logic [64:0] model(input logic [1:0] m_op, input logic [31:0] m_a, input logic [31:0] m_b);
        longint          sa;
        longint          sb;
        longint          sq;
        longint          sr;
        longint unsigned uq;
        longint unsigned ur;
        logic [63:0]     r;
        sa = longint'($signed(m_a));
        sb = longint'($signed(m_b));
        r  = '0;
        case (m_op)
            2'b00: r = 64'(sa * sb);
            2'b01: r = {32'b0, m_a} * {32'b0, m_b};
            default: begin
                if (m_b == 32'b0)
                    return {1'b1, m_a, ONES};
                if (m_op == 2'b10) begin
                    if (m_a == MIN && m_b == ONES)
                        return {1'b0, 32'b0, MIN};
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr[31:0], sq[31:0]};
                end else begin
                    uq = longint'(m_a) / longint'(m_b);
                    ur = longint'(m_a) % longint'(m_b);
                    r  = {ur[31:0], uq[31:0]};
                end
            end
        endcase
        return {1'b0, r};
    endfunction

    task automatic run_op(input logic [1:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                          input int hold, input bit chain, input string tag);
        logic [64:0] exp;
        bit          special;
        int          lat;
        int          busy_bad;
        int          hold_bad;
        exp     = model(t_op, t_a, t_b);
        special = t_op[1] && (t_b == 32'b0 || (t_op == 2'b10 && t_a == MIN && t_b == ONES));
        check({tag, "/ready_idle"}, 64'(in_ready), 64'(1));
        op = t_op; a = t_a; b = t_b; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        lat = 1; busy_bad = 0;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_bad++;
            tick;
            lat++;
        end
        check({tag, "/latency"}, 64'(lat), 64'((BYPASS && special) ? 2 : WIDTH + 2));
        check({tag, "/busy"}, 64'(busy_bad), 64'(0));
        check({tag, "/result"}, result, exp[63:0]);
        check({tag, "/dz"}, 64'(div_by_zero), 64'(exp[64]));
        hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            tick;
            if (result !== exp[63:0] || div_by_zero !== exp[64] || out_valid !== 1'b1 || in_ready !== 1'b0)
                hold_bad++;
        end
        check({tag, "/hold"}, 64'(hold_bad), 64'(0));
        out_ready = 1'b1;
        if (chain) in_valid = 1'b1;
        tick;
        out_ready = 1'b0;
        check({tag, "/retired"}, 64'(out_valid), 64'(0));
        check({tag, "/no_accept_on_retire"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        int rises;
        int r;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 2'b00; a = '0; b = '0;
        tick;
        check("reset/in_ready", 64'(in_ready), 64'(1));
        tick;
        check("reset/out_valid", 64'(out_valid), 64'(0));
        check("reset/result", result, 64'(0));
        check("reset/dz", 64'(div_by_zero), 64'(0));
        rst = 1'b0;
        tick;

        run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0003, 2, 1'b0, "mul_neg");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b1, "mulu_max");
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0, "div_neg");
        run_op(2'b11, 32'h0000_0064, 32'h0000_0000, 1, 1'b0, "divu_zero");
        run_op(2'b10, 32'hFFFF_FF9C, 32'h0000_0000, 0, 1'b0, "div_zero_neg");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b0, "div_ovf");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 1'b0, "mul_min");

        // Flush at cycle 10 of a multiply, alongside a new request that must not be taken
        op = 2'b00; a = 32'h1234_5678; b = 32'h0000_0077; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (9) tick;
        flush = 1'b1; in_valid = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        check("flush/in_ready", 64'(in_ready), 64'(1));
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) rises++;
            tick;
        end
        check("flush/no_out_valid", 64'(rises), 64'(0));
        run_op(2'b00, 32'h1234_5678, 32'h0000_0077, 5, 1'b0, "after_flush");

        // Flush while a result waits in DONE
        op = 2'b11; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 200 && !out_valid; i++) tick;
        check("flush_done/valid_before", 64'(out_valid), 64'(1));
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("flush_done/valid_dropped", 64'(out_valid), 64'(0));
        check("flush_done/in_ready", 64'(in_ready), 64'(1));

        // Reset mid-operation, together with flush
        op = 2'b10; a = 32'd99; b = 32'd4; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (5) tick;
        rst = 1'b1; flush = 1'b1;
        tick;
        rst = 1'b0; flush = 1'b0;
        check("rst_mid/in_ready", 64'(in_ready), 64'(1));
        check("rst_mid/result", result, 64'(0));
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) rises++;
            tick;
        end
        check("rst_mid/no_out_valid", 64'(rises), 64'(0));

        for (int n = 0; n < 30; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            r   = $urandom_range(0, 9);
            if (r == 0) rb = 32'b0;
            else if (r == 1) begin rop = 2'b10; ra = MIN; rb = ONES; end
            else if (r == 2) rb = 32'($urandom_range(1, 15));
            else if (r == 3) rb = -32'($urandom_range(1, 15));
            run_op(rop, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
            in_valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
